// File: rtl/io_bus_master.sv
// I/O bus initiator: setup-strobe-hold access with wait states,
// ack timeout and one-cycle response back to the CPU side.
module io_bus_master #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic [7:0] addr,
  output logic       rd,
  output logic       wr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  input  logic       ack
);

  localparam logic [3:0] WAIT_C = 4'(WAIT_STATES);
  localparam logic [3:0] TMO_C  = 4'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_e;

  state_e     state_q, state_d;
  logic       op_wr_q, op_wr_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] cap_q, cap_d;
  logic       ready_q, ready_d;
  logic       rv_q, rv_d;
  logic [7:0] rr_q, rr_d;
  logic       re_q, re_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    ready_d = ready_q;
    rv_d    = 1'b0;
    rr_d    = 8'h00;
    re_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          ready_d = 1'b0;
          op_wr_d = req_wr;
          err_d   = |req_addr[7:6];
          cap_d   = 8'h00;
          cnt_d   = 4'd0;
          if (|req_addr[7:6]) begin
            // no device lives above 0x3F: answer without touching the bus
            state_d = S_RESP;
            rv_d    = 1'b1;
            re_d    = 1'b1;
          end else begin
            state_d = S_SETUP;
            addr_d  = req_addr;
            wdata_d = req_wr ? req_wdata : 8'h00;
          end
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = 4'd0;
        rd_d    = ~op_wr_q;
        wr_d    = op_wr_q;
      end
      S_STROBE: begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        if (ack && cnt_q >= WAIT_C) begin
          state_d = S_HOLD;
          cap_d   = op_wr_q ? 8'h00 : rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (cnt_q == TMO_C) begin
          state_d = S_HOLD;
          err_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      S_HOLD: begin
        state_d = S_RESP;
        rv_d    = 1'b1;
        re_d    = err_q;
        rr_d    = err_q ? 8'h00 : cap_q;
        addr_d  = 8'h00;
        wdata_d = 8'h00;
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = 8'h00;
        wdata_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
      cap_q   <= 8'h00;
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      rr_q    <= 8'h00;
      re_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      rr_q    <= rr_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rv_q;
  assign resp_rdata = rr_q;
  assign resp_err   = re_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign rd         = rd_q;
  assign wr         = wr_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: driver pushes expected
// responses, a negedge monitor pops and compares them.
module tb_io_bus_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic [7:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] wdata;
  logic [7:0] rdata = 8'h00;
  logic       ack = 1'b0;

  io_bus_master #(.WAIT_STATES(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
    .rdata(rdata), .ack(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    logic       oor;
    int         lat;
    int         nrd;
    int         nwr;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int ack_mode = 0;
  int ack_dly = 0;
  int sc = 0;
  int nrd = 0;
  int nwr = 0;
  bit bad = 1'b0;

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, expv, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // device model: ack always, never, or after ack_dly strobe cycles
  always @(negedge clk) begin
    sc = (rd | wr) ? sc + 1 : 0;
    case (ack_mode)
      0:       ack = 1'b1;
      1:       ack = 1'b0;
      default: ack = (sc > ack_dly);
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      nrd = 0;
      nwr = 0;
      bad = 1'b0;
      if (resp_valid) chk("resp_in_reset", 1, 0);
    end else begin
      if (rd && wr) bad = 1'b1;
      if (rd) nrd++;
      if (wr) nwr++;
      if (sb.size() > 0) begin
        if ((rd | wr) && (addr != sb[0].addr ||
            wdata != sb[0].wdata)) bad = 1'b1;
        if (sb[0].oor && addr != 8'h00) bad = 1'b1;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", int'(resp_rdata), int'(e.rdata));
          chk("resp_err", int'(resp_err), int'(e.err));
          chk("latency", cyc - e.acc - 1, e.lat);
          chk("rd_cycles", nrd, e.nrd);
          chk("wr_cycles", nwr, e.nwr);
          chk("bus_ok", int'(bad), 0);
        end
        nrd = 0;
        nwr = 0;
        bad = 1'b0;
      end
    end
  end

  task automatic issue(bit w, logic [7:0] a, logic [7:0] wd,
                       logic [7:0] rdv, bit er, int lat,
                       int erd, int ewr);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = w;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    e.addr  = a;
    e.wdata = w ? wd : 8'h00;
    e.rdata = rdv;
    e.err   = er;
    e.oor   = (a[7:6] != 2'b00);
    e.lat   = lat;
    e.nrd   = erd;
    e.nwr   = ewr;
    e.acc   = cyc;
    last_acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = 1'b0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a1;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_rdata", int'(resp_rdata), 0);
    chk("rst_resp_err", int'(resp_err), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_rd", int'(rd), 0);
    chk("rst_wr", int'(wr), 0);
    chk("rst_wdata", int'(wdata), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    ack_mode = 0;
    issue(1, 8'h15, 8'hA5, 8'h00, 0, 5, 0, 3);
    drain();

    ack_mode = 2;
    ack_dly = 5;
    rdata = 8'h3C;
    issue(0, 8'h2C, 8'h00, 8'h3C, 0, 8, 6, 0);
    drain();

    ack_mode = 1;
    rdata = 8'h77;
    issue(0, 8'h30, 8'h00, 8'h00, 1, 18, 16, 0);
    drain();

    ack_mode = 0;
    issue(1, 8'h80, 8'h5E, 8'h00, 1, 0, 0, 0);
    drain();

    ack_mode = 1;
    issue(1, 8'h05, 8'h99, 8'h00, 0, 0, 0, 0);
    req_valid = 1'b0;
    n = 0;
    while (!wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_wr", int'(wr), 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_wr", int'(wr), 0);
    chk("mid_rst_addr", int'(addr), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", int'(req_ready), 1);
    ack_mode = 0;
    rdata = 8'h5A;
    issue(0, 8'h05, 8'h00, 8'h5A, 0, 5, 3, 0);
    drain();

    rdata = 8'hC3;
    issue(1, 8'h10, 8'h42, 8'h00, 0, 5, 0, 3);
    a1 = last_acc;
    issue(0, 8'h1F, 8'h00, 8'hC3, 0, 5, 3, 0);
    chk("b2b_gap", last_acc - a1, 7);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
Initiator side of the 8-bit I/O bus that the chip-select decoder serves. It accepts single read/write requests from a CPU-side port and drives addr/rd/wr/wdata through a setup-strobe-hold cycle with programmable wait states. It samples the device acknowledge and rdata, then returns a one-cycle response. It sits between the CPU core model and the decoder plus device registers on the lab board.

Parameters:
WAIT_STATES, 2, minimum extra STROBE cycles before ack is honoured (0..14)
TIMEOUT, 15, STROBE cycle count at which a missing ack aborts the access; must satisfy TIMEOUT > WAIT_STATES, max 15

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  master idle and able to accept a request
req_wr  input  1  1 = write, 0 = read
req_addr  input  8  target I/O address
req_wdata  input  8  write data
resp_valid  output  1  one-cycle pulse: access finished
resp_rdata  output  8  read data, valid with resp_valid on reads; 0x00 on writes and errors
resp_err  output  1  valid with resp_valid: out-of-range address or timeout
addr  output  8  I/O bus address
rd  output  1  read strobe, active high
wr  output  1  write strobe, active high
wdata  output  8  I/O bus write data
rdata  input  8  I/O bus read data from selected device
ack  input  1  device ready; sampled only in STROBE

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1. All of the following are 0/0x00: resp_valid, resp_rdata, resp_err, addr, rd, wr, wdata, wait counter.
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE: req_ready=1. On req_valid=1, latch req_wr, req_addr and req_wdata.
  - If req_addr[7:6]!=0 (no device above 0x3F), go to RESP with err flag set; no bus strobe is ever issued.
  - Otherwise go to SETUP.
- SETUP (1 cycle): addr=latched address. wdata=latched data on writes, 0x00 on reads. rd=wr=0. Wait counter cleared. Next state is STROBE.
- STROBE: addr/wdata held. rd=1 for reads, wr=1 for writes; rd and wr are never both 1. Counter increments every STROBE cycle (4 bits, saturating).
  - counter==WAIT_STATES and ack=1 at a rising edge: capture rdata (reads only), go to HOLD.
  - counter>=WAIT_STATES and ack=1 on a later edge: same exit as above.
  - ack=1 while counter<WAIT_STATES: ignored.
  - counter==TIMEOUT and ack=0: set err flag, go to HOLD; rdata is not captured.
  - Timeout has priority only when ack=0; ack=1 on the timeout cycle completes normally.
- HOLD (1 cycle): rd=wr=0, addr/wdata still driven. Next state is RESP.
- RESP (1 cycle): resp_valid=1, resp_err=err flag, resp_rdata as captured (0x00 if write or error). addr/wdata return to 0x00. Next state is IDLE; resp_* return to 0 in IDLE.
- req_ready=0 in every state except IDLE. req_valid while busy is ignored and not queued; the CPU must hold req_valid until it observes req_ready=1 together with req_valid at an edge.
- Latency, ack tied high: acceptance edge → resp_valid at cycle 4+WAIT_STATES. With WAIT_STATES=2 this is cycle 6 (SETUP 1, STROBE 3, HOLD 1, RESP 1).
- Out-of-range latency: resp_valid at the cycle after acceptance.
- Back-to-back: a new request may be accepted on the edge leaving RESP→IDLE +1, i.e. at minimum one IDLE cycle between accesses.
- Reset mid-access: strobes drop asynchronously, no resp_valid is produced, and the latched request is discarded.

Test Plan:
- Write req_addr=0x15, req_wdata=0xA5, ack=1 → addr=0x15 from SETUP to HOLD, wr=1 for exactly 3 cycles, rd=0 throughout, resp_valid at acceptance+6, resp_err=0, resp_rdata=0x00.
- Read req_addr=0x2C, device rdata=0x3C, ack asserted 5 cycles into STROBE → rd=1 for 6 cycles, resp_rdata=0x3C, resp_err=0.
- Read 0x30 with ack held 0 → rd high for 16 STROBE cycles (counter 0..15), then resp_valid with resp_err=1, resp_rdata=0x00.
- Write req_addr=0x80 → resp_valid one cycle after acceptance with resp_err=1; rd, wr and addr stay 0 for the whole transaction.
- rst_n pulled low during STROBE of a write to 0x05 → wr and addr are 0 immediately; no resp_valid; after release, req_ready=1 and a read of 0x05 completes normally.
- req_valid held high across two back-to-back requests (0x10 write, 0x1F read) → second request accepted only after RESP; no overlap of strobes; req_ready=0 during the first access.
